// File: rtl/cpu_pkg.sv
// Constants shared by the decoder and fetch stage: branch compare codes,
// the canonical NOP encoding and the default reset PC.
package cpu_pkg;

  localparam logic [2:0] CMP_NONE = 3'b000;
  localparam logic [2:0] CMP_BEQ  = 3'b001;
  localparam logic [2:0] CMP_BNE  = 3'b010;
  localparam logic [2:0] CMP_BLEZ = 3'b011;
  localparam logic [2:0] CMP_BGTZ = 3'b100;
  localparam logic [2:0] CMP_BLTZ = 3'b101;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation on forwarded ID-stage operands.
module branch_compare
  import cpu_pkg::*;
(
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [2:0]  cmp,
  output logic        taken
);

  logic w_rs_neg;
  logic w_rs_zero;

  assign w_rs_neg  = rs[31];
  assign w_rs_zero = (rs == 32'h0);

  always_comb begin
    taken = 1'b0;
    case (cmp)
      CMP_BEQ:  taken = (rs == rt);
      CMP_BNE:  taken = (rs != rt);
      CMP_BLEZ: taken = w_rs_neg | w_rs_zero;
      CMP_BGTZ: taken = ~w_rs_neg & ~w_rs_zero;
      CMP_BLTZ: taken = w_rs_neg;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage with PC and IF/ID registers; resolves branches/jumps in ID and
// redirects fetch with a single-bubble flush.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  input  logic        id_branch,
  input  logic [2:0]  id_branch_cmp,
  input  logic        id_jump,
  input  logic        id_jump_src,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  output logic        redirect,
  output logic [31:0] redirect_count
);

  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [31:0] r_count;

  logic        w_cmp_true;
  logic        w_taken_br;
  logic        w_do_jump;
  logic        w_redirect;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_target;

  branch_compare u_branch_compare (
    .rs    (id_rs_data),
    .rt    (id_rt_data),
    .cmp   (id_branch_cmp),
    .taken (w_cmp_true)
  );

  // A bubble (valid=0) can never redirect, so redirects are never back-to-back.
  assign w_taken_br = r_valid & id_branch & w_cmp_true;
  assign w_do_jump  = r_valid & id_jump;
  assign w_redirect = ~stall & (w_taken_br | w_do_jump);

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_target = r_pc4 + {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
  assign w_j_target  = {r_pc4[31:28], r_inst[25:0], 2'b00};

  always_comb begin
    w_target = w_br_target;
    if (w_do_jump) begin
      w_target = id_jump_src ? id_rs_data : w_j_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_inst  <= NOP_INST;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
      r_count <= 32'h0;
    end else if (!stall) begin
      if (w_redirect) begin
        r_pc    <= w_target;
        r_inst  <= NOP_INST;
        r_pc4   <= 32'h0;
        r_valid <= 1'b0;
        r_count <= r_count + 32'd1;
      end else begin
        r_pc    <= w_pc_plus4;
        r_inst  <= imem_data;
        r_pc4   <= w_pc_plus4;
        r_valid <= 1'b1;
      end
    end
  end

  assign imem_addr      = r_pc;
  assign if_id_inst     = r_inst;
  assign if_id_pc4      = r_pc4;
  assign if_id_valid    = r_valid;
  assign redirect       = w_redirect;
  assign redirect_count = r_count;

endmodule
